// File: rtl/avalon_st_checker_pkg.sv
// Shared constants, register map and FSM encoding for the Avalon-ST pattern checker.
package avalon_st_checker_pkg;

  localparam int SAMP_W = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [31:0] ID_VALUE       = 32'hA515_C4EC;
  localparam logic [31:0] VERSION_VALUE  = 32'h0000_0100;
  localparam logic [31:0] BAD_ADDR_VALUE = 32'hDEAD_BEEF;

  localparam logic [3:0] ADDR_ID              = 4'd0;
  localparam logic [3:0] ADDR_VERSION         = 4'd1;
  localparam logic [3:0] ADDR_ZERO            = 4'd2;
  localparam logic [3:0] ADDR_SCRATCH         = 4'd3;
  localparam logic [3:0] ADDR_STATUS          = 4'd4;
  localparam logic [3:0] ADDR_CONTROL         = 4'd5;
  localparam logic [3:0] ADDR_BP_THR          = 4'd6;
  localparam logic [3:0] ADDR_EXPECTED_BYTES  = 4'd8;
  localparam logic [3:0] ADDR_RX_BYTES        = 4'd9;
  localparam logic [3:0] ADDR_ERR_BEATS       = 4'd10;
  localparam logic [3:0] ADDR_FIRST_ERR_IDX   = 4'd11;
  localparam logic [3:0] ADDR_FIRST_ERR_LANE0 = 4'd12;
  localparam logic [3:0] ADDR_RUN_CYCLES      = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/avalon_st_checker_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with synchronous reload.
module avalon_st_checker_lfsr
  import avalon_st_checker_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        load,
  output logic [15:0] value
);

  logic feedback;

  assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end else if (load) begin
      value <= seed;
    end else begin
      value <= {feedback, value[15:1]};
    end
  end

endmodule

// File: rtl/avalon_st_checker.sv
// Avalon-ST sink that checks an incrementing 16-bit lane pattern, applies
// LFSR-driven backpressure and reports counters through a small CSR slave.
module avalon_st_checker
  import avalon_st_checker_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              csi_clk_clk,
  input  logic              rsi_reset_reset,
  input  logic [3:0]        avs_ctrl_address,
  input  logic              avs_ctrl_read,
  input  logic              avs_ctrl_write,
  input  logic [31:0]       avs_ctrl_writedata,
  output logic [31:0]       avs_ctrl_readdata,
  input  logic [DATA_W-1:0] asi_data_data,
  input  logic              asi_data_valid,
  output logic              asi_data_ready
);

  // state      | meaning
  // IDLE       | not started, sink held off
  // WAIT_FIRST | armed, waiting for the first accepted beat
  // RUN        | streaming, counting and checking beats
  // DONE       | expected byte count reached, sink held off

  localparam int          LANES      = DATA_W / SAMP_W;
  localparam logic [31:0] BEAT_BYTES = 32'(DATA_W / 8);

  function automatic logic [DATA_W-1:0] lane_init();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*SAMP_W +: SAMP_W] = SAMP_W'(i);
    return v;
  endfunction

  localparam logic [DATA_W-1:0] EXP_INIT = lane_init();

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [7:0]        lfsr_unused_hi;
  logic [31:0]       scratch, expected_bytes;
  logic [7:0]        bp_thr;
  logic [31:0]       rx_bytes, err_beats, first_err_byte_idx, run_cycles;
  logic [15:0]       first_err_lane0;
  logic              error_sticky;
  logic [DATA_W-1:0] exp_vec, exp_adv;
  logic              cmp_valid, cmp_bad;
  logic [31:0]       cmp_idx;
  logic [15:0]       cmp_lane0;
  logic              ctrl_wr, start, clear_err, running, accept, last_beat, run_tick;
  logic [31:0]       rx_next, rd_mux;

  assign ctrl_wr   = avs_ctrl_write && (avs_ctrl_address == ADDR_CONTROL);
  assign start     = ctrl_wr && avs_ctrl_writedata[0];
  assign clear_err = ctrl_wr && avs_ctrl_writedata[1] && !avs_ctrl_writedata[0];

  assign running        = (state == ST_WAIT_FIRST) || (state == ST_RUN);
  assign asi_data_ready = running && ((bp_thr == 8'd0) || (lfsr[7:0] >= bp_thr));
  assign accept         = asi_data_valid && asi_data_ready;
  assign rx_next        = sat_add32(rx_bytes, BEAT_BYTES);
  assign last_beat      = accept && (rx_next >= expected_bytes);
  assign run_tick       = (state == ST_RUN) || ((state == ST_WAIT_FIRST) && accept);
  assign lfsr_unused_hi = lfsr[15:8];

  avalon_st_checker_lfsr u_lfsr (
    .clk_sys (csi_clk_clk),
    .rst     (rsi_reset_reset),
    .seed    (LFSR_SEED),
    .load    (start),
    .value   (lfsr)
  );

  always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // A single-beat run finishes straight from WAIT_FIRST so DONE always follows the last beat.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (expected_bytes == 32'd0) ? ST_DONE : ST_WAIT_FIRST;
    end else begin
      case (state)
        ST_WAIT_FIRST: if (accept) state_nxt = last_beat ? ST_DONE : ST_RUN;
        ST_RUN:        if (last_beat) state_nxt = ST_DONE;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) begin
      scratch        <= '0;
      bp_thr         <= '0;
      expected_bytes <= '0;
    end else if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        ADDR_SCRATCH:        scratch        <= avs_ctrl_writedata;
        ADDR_BP_THR:         bp_thr         <= avs_ctrl_writedata[7:0];
        ADDR_EXPECTED_BYTES: expected_bytes <= avs_ctrl_writedata;
        default:             ;
      endcase
    end
  end

  always_comb begin
    exp_adv = exp_vec;
    for (int i = 0; i < LANES; i++) begin
      exp_adv[i*SAMP_W +: SAMP_W] = exp_vec[i*SAMP_W +: SAMP_W] + SAMP_W'(LANES);
    end
  end

  always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) begin
      rx_bytes   <= '0;
      run_cycles <= '0;
      exp_vec    <= EXP_INIT;
      cmp_valid  <= 1'b0;
      cmp_bad    <= 1'b0;
      cmp_idx    <= '0;
      cmp_lane0  <= '0;
    end else if (start) begin
      rx_bytes   <= '0;
      run_cycles <= '0;
      exp_vec    <= EXP_INIT;
      cmp_valid  <= 1'b0;
      cmp_bad    <= 1'b0;
    end else begin
      cmp_valid <= accept;
      if (accept) begin
        rx_bytes  <= rx_next;
        exp_vec   <= exp_adv;
        cmp_bad   <= (asi_data_data != exp_vec);
        cmp_idx   <= rx_bytes;
        cmp_lane0 <= asi_data_data[SAMP_W-1:0];
      end
      if (run_tick) run_cycles <= sat_add32(run_cycles, 32'd1);
    end
  end

  // error_sticky doubles as the "first error already captured" flag.
  always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) begin
      err_beats          <= '0;
      error_sticky       <= 1'b0;
      first_err_byte_idx <= '0;
      first_err_lane0    <= '0;
    end else if (start || clear_err) begin
      err_beats          <= '0;
      error_sticky       <= 1'b0;
      first_err_byte_idx <= '0;
      first_err_lane0    <= '0;
    end else if (cmp_valid && cmp_bad) begin
      err_beats    <= sat_add32(err_beats, 32'd1);
      error_sticky <= 1'b1;
      if (!error_sticky) begin
        first_err_byte_idx <= cmp_idx;
        first_err_lane0    <= cmp_lane0;
      end
    end
  end

  always_comb begin
    rd_mux = BAD_ADDR_VALUE;
    case (avs_ctrl_address)
      ADDR_ID:              rd_mux = ID_VALUE;
      ADDR_VERSION:         rd_mux = VERSION_VALUE;
      ADDR_ZERO:            rd_mux = '0;
      ADDR_SCRATCH:         rd_mux = scratch;
      ADDR_STATUS:          rd_mux = {29'd0, error_sticky, (state == ST_DONE), running};
      ADDR_CONTROL:         rd_mux = '0;
      ADDR_BP_THR:          rd_mux = {24'd0, bp_thr};
      ADDR_EXPECTED_BYTES:  rd_mux = expected_bytes;
      ADDR_RX_BYTES:        rd_mux = rx_bytes;
      ADDR_ERR_BEATS:       rd_mux = err_beats;
      ADDR_FIRST_ERR_IDX:   rd_mux = first_err_byte_idx;
      ADDR_FIRST_ERR_LANE0: rd_mux = {16'd0, first_err_lane0};
      ADDR_RUN_CYCLES:      rd_mux = run_cycles;
      default:              rd_mux = BAD_ADDR_VALUE;
    endcase
  end

  always_ff @(posedge csi_clk_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset)    avs_ctrl_readdata <= '0;
    else if (avs_ctrl_read) avs_ctrl_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_avalon_st_checker.sv
// Directed + randomized bench for avalon_st_checker against a beat-level reference model.
module tb_avalon_st_checker;

  localparam int DATA_W     = 256;
  localparam int LANES      = DATA_W / 16;
  localparam int BEAT_BYTES = DATA_W / 8;

  logic              csi_clk_clk = 1'b0;
  logic              rsi_reset_reset = 1'b1;
  logic [3:0]        avs_ctrl_address = '0;
  logic              avs_ctrl_read = 1'b0;
  logic              avs_ctrl_write = 1'b0;
  logic [31:0]       avs_ctrl_writedata = '0;
  logic [31:0]       avs_ctrl_readdata;
  logic [DATA_W-1:0] asi_data_data = '0;
  logic              asi_data_valid = 1'b0;
  logic              asi_data_ready;

  int checks = 0;
  int failures = 0;

  avalon_st_checker #(.DATA_W(DATA_W)) dut (
    .csi_clk_clk        (csi_clk_clk),
    .rsi_reset_reset    (rsi_reset_reset),
    .avs_ctrl_address   (avs_ctrl_address),
    .avs_ctrl_read      (avs_ctrl_read),
    .avs_ctrl_write     (avs_ctrl_write),
    .avs_ctrl_writedata (avs_ctrl_writedata),
    .avs_ctrl_readdata  (avs_ctrl_readdata),
    .asi_data_data      (asi_data_data),
    .asi_data_valid     (asi_data_valid),
    .asi_data_ready     (asi_data_ready)
  );

  always #5 csi_clk_clk = ~csi_clk_clk;

  // Reference model state (beat-level view of a run)
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  m_thr = '0;
  logic [31:0] m_exp = '0;
  bit          m_active = 1'b0;
  longint      m_beats = 0;
  logic [31:0] m_err = '0;
  bit          m_sticky = 1'b0;
  logic [31:0] m_first_idx = '0;
  logic [15:0] m_first_lane0 = '0;
  bit          pend = 1'b0;
  logic [31:0] pend_idx = '0;
  logic [15:0] pend_lane0 = '0;
  longint      cyc = 0;
  longint      m_first_cyc = 0;
  longint      m_last_cyc = 0;
  int          ready_errs = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & 16'h002D), v[15:1]};
  endfunction

  function automatic logic [DATA_W-1:0] golden(input longint k);
    logic [DATA_W-1:0] g;
    for (int i = 0; i < LANES; i++) g[i*16 +: 16] = 16'((k * LANES + i) % 65536);
    return g;
  endfunction

  function automatic longint m_run();
    return (m_beats == 0) ? 0 : (m_last_cyc - m_first_cyc + 1);
  endfunction

  always @(negedge csi_clk_clk) begin : model
    bit st, clr, acc, exp_rdy;
    cyc++;
    if (rsi_reset_reset) begin
      if (asi_data_ready !== 1'b0) ready_errs++;
      m_lfsr = 16'hACE1; m_thr = '0; m_exp = '0; m_active = 1'b0; m_beats = 0;
      m_err = '0; m_sticky = 1'b0; m_first_idx = '0; m_first_lane0 = '0; pend = 1'b0;
      m_first_cyc = 0; m_last_cyc = 0;
    end else begin
      st  = avs_ctrl_write && (avs_ctrl_address == 4'd5) && avs_ctrl_writedata[0];
      clr = avs_ctrl_write && (avs_ctrl_address == 4'd5) && avs_ctrl_writedata[1] && !avs_ctrl_writedata[0];
      exp_rdy = m_active && ((m_thr == 8'd0) || (m_lfsr[7:0] >= m_thr));
      if (asi_data_ready !== exp_rdy) ready_errs++;
      acc = asi_data_valid && asi_data_ready;
      if (pend && !clr && !st) begin
        if (!m_sticky) begin
          m_first_idx = pend_idx;
          m_first_lane0 = pend_lane0;
        end
        m_sticky = 1'b1;
        m_err++;
      end
      pend = 1'b0;
      if (clr) begin
        m_err = '0; m_sticky = 1'b0; m_first_idx = '0; m_first_lane0 = '0;
      end
      if (acc && m_active) begin
        pend = (asi_data_data !== golden(m_beats));
        pend_idx = 32'(m_beats * BEAT_BYTES);
        pend_lane0 = asi_data_data[15:0];
        if (m_beats == 0) m_first_cyc = cyc;
        m_last_cyc = cyc;
        m_beats++;
        if (m_beats * BEAT_BYTES >= longint'(m_exp)) m_active = 1'b0;
      end
      if (avs_ctrl_write && avs_ctrl_address == 4'd6) m_thr = avs_ctrl_writedata[7:0];
      if (avs_ctrl_write && avs_ctrl_address == 4'd8) m_exp = avs_ctrl_writedata;
      if (st) begin
        m_lfsr = 16'hACE1; m_beats = 0; m_err = '0; m_sticky = 1'b0;
        m_first_idx = '0; m_first_lane0 = '0; pend = 1'b0;
        m_first_cyc = 0; m_last_cyc = 0;
        m_active = (m_exp != 32'd0);
      end else begin
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge csi_clk_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avs_ctrl_address = a;
    avs_ctrl_writedata = d;
    avs_ctrl_write = 1'b1;
    tick();
    avs_ctrl_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    avs_ctrl_address = a;
    avs_ctrl_read = 1'b1;
    tick();
    avs_ctrl_read = 1'b0;
    d = avs_ctrl_readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, e);
  endtask

  task automatic run_stream(input int valid_pct, input int corrupt_pct, input longint force_beat,
                            input int force_lane, input int max_cyc);
    logic [DATA_W-1:0] d;
    int n;
    int ln;
    n = 0;
    while (m_active && n < max_cyc) begin
      d = golden(m_beats);
      if (m_beats == force_beat) d[force_lane*16 +: 16] = d[force_lane*16 +: 16] ^ 16'hFFFF;
      if (int'($urandom_range(99)) < corrupt_pct) begin
        ln = int'($urandom_range(LANES - 1));
        d[ln*16 +: 16] = d[ln*16 +: 16] ^ 16'($urandom_range(65535, 1));
      end
      asi_data_data = d;
      asi_data_valid = (int'($urandom_range(99)) < valid_pct);
      tick();
      n++;
    end
    asi_data_valid = 1'b0;
    check("stream_completed", {63'd0, m_active}, 64'd0);
    tick();
  endtask

  initial begin
    logic [31:0] d;
    rsi_reset_reset = 1'b1;
    repeat (3) @(posedge csi_clk_clk);
    #1;
    rsi_reset_reset = 1'b0;
    check("rst_readdata", avs_ctrl_readdata, 0);
    check("rst_ready", asi_data_ready, 0);

    rd_chk("id", 4'd0, 32'hA515C4EC);
    rd_chk("version", 4'd1, 32'h00000100);
    rd_chk("zero_reg", 4'd2, 0);
    rd_chk("rst_scratch", 4'd3, 0);
    rd_chk("rst_status", 4'd4, 0);
    rd_chk("control_reads0", 4'd5, 0);
    rd_chk("rst_bp_thr", 4'd6, 0);
    rd_chk("bad_addr7", 4'd7, 32'hDEADBEEF);
    rd_chk("rst_exp_bytes", 4'd8, 0);
    rd_chk("rst_rx_bytes", 4'd9, 0);
    rd_chk("rst_err_beats", 4'd10, 0);
    rd_chk("rst_first_idx", 4'd11, 0);
    rd_chk("rst_first_lane0", 4'd12, 0);
    rd_chk("rst_run_cycles", 4'd13, 0);
    rd_chk("bad_addr15", 4'd15, 32'hDEADBEEF);

    wr(4'd3, 32'h1234_5678);
    rd_chk("scratch_rw", 4'd3, 32'h1234_5678);
    wr(4'd6, 32'h0000_01FF);
    rd_chk("bp_thr_8bit", 4'd6, 32'h0000_00FF);

    // clean run
    wr(4'd6, 0); wr(4'd8, 1024); wr(4'd5, 1);
    run_stream(100, 0, -1, 0, 2000);
    rd_chk("clean_rx", 4'd9, 1024);
    rd_chk("clean_err", 4'd10, 0);
    rd_chk("clean_status", 4'd4, 32'h2);
    rd_chk("clean_run_cycles", 4'd13, 32);

    // single corruption: lane 3 of beat 5
    wr(4'd5, 1);
    run_stream(100, 0, 5, 3, 2000);
    rd_chk("corrupt_err", 4'd10, 1);
    rd_chk("corrupt_idx", 4'd11, 160);
    rd_chk("corrupt_lane0", 4'd12, 32'h0050);
    rd_chk("corrupt_status", 4'd4, 32'h6);
    wr(4'd5, 2);
    rd_chk("clear_err", 4'd10, 0);
    rd_chk("clear_status", 4'd4, 32'h2);
    rd_chk("clear_idx", 4'd11, 0);
    rd_chk("clear_lane0", 4'd12, 0);
    rd_chk("clear_keeps_rx", 4'd9, 1024);

    // backpressure
    wr(4'd6, 32'h80); wr(4'd8, 4096); wr(4'd5, 1);
    run_stream(75, 0, -1, 0, 20000);
    rd_chk("bp_rx", 4'd9, 4096);
    rd_chk("bp_err", 4'd10, 0);
    rd(4'd13, d);
    check("bp_run_gt128", {63'd0, (d > 32'd128)}, 1);
    check("bp_run_model", d, m_run());
    check("bp_ready_model", ready_errs, 0);

    // randomized runs with random corruption
    for (int r = 0; r < 4; r++) begin
      wr(4'd6, $urandom_range(192));
      wr(4'd8, 32'(BEAT_BYTES * $urandom_range(40, 2)));
      wr(4'd5, (r % 2 == 0) ? 32'd3 : 32'd1);
      run_stream(int'($urandom_range(100, 40)), 15, -1, 0, 8000);
      rd_chk("rand_rx", 4'd9, 32'(m_beats * BEAT_BYTES));
      rd_chk("rand_err", 4'd10, m_err);
      rd_chk("rand_first_idx", 4'd11, m_first_idx);
      rd_chk("rand_first_lane0", 4'd12, {16'd0, m_first_lane0});
      rd_chk("rand_status", 4'd4, {29'd0, m_sticky, 1'b1, 1'b0});
      rd_chk("rand_run", 4'd13, 32'(m_run()));
    end
    check("rand_ready_model", ready_errs, 0);

    // lane wrap past 0xFFFF
    wr(4'd6, 0); wr(4'd8, 32'h0004_0000); wr(4'd5, 1);
    run_stream(100, 0, -1, 0, 9000);
    rd_chk("wrap_rx", 4'd9, 32'h0004_0000);
    rd_chk("wrap_err", 4'd10, 0);
    rd_chk("wrap_status", 4'd4, 32'h2);

    // zero-length run
    wr(4'd8, 0); wr(4'd5, 1);
    rd_chk("zero_status", 4'd4, 32'h2);
    asi_data_data = golden(0);
    asi_data_valid = 1'b1;
    repeat (8) tick();
    asi_data_valid = 1'b0;
    rd_chk("zero_rx", 4'd9, 0);
    check("zero_ready_model", ready_errs, 0);

    // reset mid-run with a corrupted beat still in the compare stage
    wr(4'd3, 32'hCAFE_0001); wr(4'd8, 4096); wr(4'd5, 1);
    for (int i = 0; i < 20; i++) begin
      asi_data_data = golden(m_beats);
      if (i == 19) asi_data_data[32 +: 16] = asi_data_data[32 +: 16] ^ 16'h00FF;
      asi_data_valid = 1'b1;
      tick();
    end
    rsi_reset_reset = 1'b1;
    asi_data_valid = 1'b0;
    tick(); tick();
    rsi_reset_reset = 1'b0;
    check("mid_rst_ready", asi_data_ready, 0);
    rd_chk("mid_rst_status", 4'd4, 0);
    rd_chk("mid_rst_scratch", 4'd3, 0);
    rd_chk("mid_rst_exp", 4'd8, 0);
    rd_chk("mid_rst_rx", 4'd9, 0);
    rd_chk("mid_rst_err", 4'd10, 0);
    rd_chk("mid_rst_idx", 4'd11, 0);
    rd_chk("mid_rst_run", 4'd13, 0);
    wr(4'd8, 1024); wr(4'd5, 1);
    run_stream(100, 0, -1, 0, 2000);
    rd_chk("post_rst_rx", 4'd9, 1024);
    rd_chk("post_rst_err", 4'd10, 0);
    rd_chk("post_rst_status", 4'd4, 32'h2);
    rd_chk("post_rst_run", 4'd13, 32);
    check("final_ready_model", ready_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_st_checker.md
AVALON_ST_CHECKER -- requirements
Module: avalon_st_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning sink data width in bits; a multiple of 16.
REQ-002 SHALL have port csi_clk_clk, input, 1, the single clock.
REQ-003 SHALL have port rsi_reset_reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port avs_ctrl_address, input, 4, register word address.
REQ-005 SHALL have ports avs_ctrl_read and avs_ctrl_write, input, 1 each, register strobes.
REQ-006 SHALL have port avs_ctrl_writedata, input, 32, write data.
REQ-007 SHALL have port avs_ctrl_readdata, output, 32, registered read data.
REQ-008 SHALL have ports asi_data_data, input, DATA_W, and asi_data_valid, input, 1: the Avalon-ST sink.
REQ-009 SHALL have port asi_data_ready, output, 1, sink backpressure.

Function
REQ-010 SHALL return readdata one cycle after the address is presented. Registers: 0 ID=0xA515C4EC; 1 version=0x00000100; 2 zero; 3 scratch (RW); 4 status (bit0 running, bit1 done, bit2 error_sticky); 5 control (W: bit0 start, bit1 clear_err; reads 0); 6 bp_thr[7:0] (RW); 8 expected_bytes (RW); 9 rx_bytes; 10 err_beats; 11 first_err_byte_idx; 12 first_err_lane0; 13 run_cycles; other addresses 0xDEADBEEF.
REQ-011 SHALL use FSM states IDLE, WAIT_FIRST, RUN, DONE; reset state IDLE.
REQ-012 A start write SHALL transition any state to WAIT_FIRST, or directly to DONE if expected_bytes==0; start SHALL clear rx_bytes, err_beats, first_err regs, run_cycles, error_sticky, and reload the expected pattern.
REQ-013 WAIT_FIRST SHALL go to RUN on the first accepted beat (valid&&ready); RUN SHALL go to DONE in the cycle after the beat that makes rx_bytes >= expected_bytes.
REQ-014 asi_data_ready SHALL be 0 in IDLE and DONE; in WAIT_FIRST/RUN it SHALL be 1 when bp_thr==0, else lfsr[7:0] >= bp_thr.
REQ-015 The LFSR SHALL be 16-bit, polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset and on start, and advance every cycle.
REQ-016 Expected lane i (16-bit, i=0..DATA_W/16-1) of beat k SHALL be (k*DATA_W/16 + i) mod 2^16, held as a vector and incremented by DATA_W/16 per accepted beat, wrapping at 16 bits.
REQ-017 Each accepted beat SHALL add DATA_W/8 to rx_bytes; counting is in bytes.
REQ-018 Compare SHALL be pipelined one stage: mismatch of any lane in accepted beat k SHALL increment err_beats and set error_sticky one cycle after acceptance.
REQ-019 On the first mismatch after start, first_err_byte_idx SHALL capture the beat's rx_bytes value before increment, and first_err_lane0 the received lane 0.
REQ-020 run_cycles SHALL count every cycle in RUN, including the first-beat cycle, and stop in DONE.
REQ-021 All 32-bit counters SHALL saturate at 0xFFFFFFFF.
REQ-022 clear_err SHALL zero err_beats, error_sticky, and first_err regs; a pipelined mismatch resolving in the same cycle SHALL be dropped (clear wins).
REQ-023 Start and clear_err written in one word SHALL act as start.
REQ-024 Beats with valid=1 while ready=0 SHALL not be counted or checked.

Reset
REQ-025 Reset SHALL set state IDLE, ready 0, readdata 0, all counters/status 0, scratch 0, bp_thr 0, expected_bytes 0, LFSR 0xACE1, expected lanes i.
REQ-026 Reset mid-RUN SHALL abort immediately; no counter update from an in-flight compare.

Structure
REQ-027 Package avalon_st_checker_pkg SHALL hold register address constants, ID/version constants, SAMP_W=16, LFSR seed, and the FSM state enum.
REQ-028 The LFSR SHALL be sub-module avalon_st_checker_lfsr (seed input, load, 16-bit output).

Verification
REQ-029 Clean run: DATA_W=256, expected_bytes=1024, bp_thr=0, correct source -> 32 beats, rx_bytes=1024, err_beats=0, status=0x2, run_cycles=32.
REQ-030 Single corruption: lane 3 of beat 5 flipped -> err_beats=1, first_err_byte_idx=160, first_err_lane0=0x0050, status bit2=1.
REQ-031 Backpressure: bp_thr=0x80, expected_bytes=4096 -> rx_bytes=4096, err_beats=0, run_cycles>128, no beat accepted with ready=0.
REQ-032 Wrap: expected_bytes=0x40000 -> lane values wrap from 0xFFFF to 0x0000 with err_beats=0.
REQ-033 Start with expected_bytes=0 -> DONE next cycle, ready never asserted, rx_bytes=0.
REQ-034 Reset asserted mid-RUN, then start -> all registers at reset values; the new run completes cleanly.
